adder_share_ctrl: RTL and testbench

- Arbitrates two requesters onto one shared 9-bit clocked ripple adder (10-bit sum).
- Registers and holds operands stable for the adder's fixed latency, samples the sum, and returns it tagged with the requester ID.
- Uses a valid/ready handshake on both the request and response sides.
- Sits between game-logic clients (e.g. score/position updaters) and the adder instance.

---
 rtl/adder_share_ctrl_pkg.sv | 17 +
 rtl/adder_share_ctrl_rr_arb2.sv | 29 ++
 rtl/adder_share_ctrl.sv | 110 +++++++++++
 tb/tb_adder_share_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for clients of the shared ripple adder: state encoding,
// requester IDs and default operand width / adder latency.
package adder_share_ctrl_pkg;

    localparam int DEF_WIDTH   = 9;
    localparam int DEF_ADD_LAT = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/adder_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request pair and
// a pointer register that moves to the losing side whenever a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // The pointer names the requester favoured on the next contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one clocked ripple adder between two requesters with valid/ready on
// both sides. Optional macro ADDER_SHARE_SAT_EN saturates the returned sum.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_in0,
    output logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH:0]   add_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_sum,
    input  logic             rsp_ready
);

    localparam int CNT_W = 8;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    logic             in_idle;
    logic             accept;
    logic [WIDTH:0]   sum_cap;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // Reset outranks any handshake, so ready is masked while it is asserted.
    assign in_idle    = (state == S_IDLE) && !reset;
    assign req0_ready = in_idle && gnt[0];
    assign req1_ready = in_idle && gnt[1];
    assign accept     = req0_ready || req1_ready;

    always_comb begin
`ifdef ADDER_SHARE_SAT_EN
        sum_cap = add_out[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : add_out;
`else
        sum_cap = add_out;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_BUSY;
            S_BUSY:  if (cnt == '0) state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operands stay registered for the whole BUSY window; the sum is sampled
    // in the last BUSY cycle, when the counter has reached zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            add_in0   <= '0;
            add_in1   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= ID_REQ0;
            rsp_sum   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        add_in0 <= gnt[1] ? req1_a : req0_a;
                        add_in1 <= gnt[1] ? req1_b : req0_b;
                        rsp_id  <= gnt[1] ? ID_REQ1 : ID_REQ0;
                        cnt     <= CNT_W'(ADD_LAT - 1);
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        rsp_sum   <= sum_cap;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a latency-accurate adder model that
// returns a wrong sum until its operands have been stable for ADD_LAT cycles.
module tb_adder_share_ctrl;
    import adder_share_ctrl_pkg::*;

    localparam int W   = DEF_WIDTH;
    localparam int LAT = DEF_ADD_LAT;
`ifdef ADDER_SHARE_SAT_EN
    localparam int OVF_SUM = 511;
`else
    localparam int OVF_SUM = 1022;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] add_in0, add_in1;
    logic [W:0]   add_out;
    logic         rsp_valid, rsp_id;
    logic [W:0]   rsp_sum;
    logic         rsp_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    adder_share_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .add_in0    (add_in0),
        .add_in1    (add_in1),
        .add_out    (add_out),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    int           stable_cnt = 0;
    logic [W-1:0] prev0 = '0, prev1 = '0;
    logic [W:0]   true_sum;

    always @(negedge clk) begin
        if (add_in0 !== prev0 || add_in1 !== prev1) stable_cnt = 1;
        else if (stable_cnt < 1000) stable_cnt++;
        prev0 = add_in0;
        prev1 = add_in1;
    end

    assign true_sum = {1'b0, add_in0} + {1'b0, add_in1};
    assign add_out  = (stable_cnt >= LAT) ? true_sum : ~true_sum;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic id, input logic valid, input int a, input int b);
        if (id == ID_REQ0) begin
            req0_valid = valid; req0_a = W'(a); req0_b = W'(b);
        end else begin
            req1_valid = valid; req1_a = W'(a); req1_b = W'(b);
        end
    endtask

    task automatic grantCheck(input logic exp_id);
        #1;
        checkOutput("grant_ready0", 32'(req0_ready), 32'(exp_id == ID_REQ0));
        checkOutput("grant_ready1", 32'(req1_ready), 32'(exp_id == ID_REQ1));
        tick();
    endtask

    // Entered in cycle T+1; returns in the first IDLE cycle after the response.
    task automatic runBusy(input int ea, input int eb, input logic eid, input int esum, input int bp);
        for (int k = 1; k <= LAT; k++) begin
            #1;
            checkOutput("busy_in0", 32'(add_in0), 32'(ea));
            checkOutput("busy_in1", 32'(add_in1), 32'(eb));
            checkOutput("busy_ready0", 32'(req0_ready), 0);
            checkOutput("busy_ready1", 32'(req1_ready), 0);
            checkOutput("busy_rsp_valid", 32'(rsp_valid), 0);
            tick();
        end
        for (int j = 0; j < bp; j++) begin
            rsp_ready = 1'b0;
            #1;
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'(eid));
            checkOutput("bp_rsp_sum", 32'(rsp_sum), 32'(esum));
            checkOutput("bp_ready0", 32'(req0_ready), 0);
            checkOutput("bp_ready1", 32'(req1_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rsp_id", 32'(rsp_id), 32'(eid));
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(esum));
        checkOutput("rsp_ready0", 32'(req0_ready), 0);
        checkOutput("rsp_ready1", 32'(req1_ready), 0);
        tick();
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) tick();
        checkOutput("rst_in0", 32'(add_in0), 0);
        checkOutput("rst_in1", 32'(add_in1), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("rst_rsp_sum", 32'(rsp_sum), 0);

        // Single request 100+27
        reset = 1'b0;
        applyStimulus(ID_REQ0, 1'b1, 100, 27);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b0, 0, 0);
        runBusy(100, 27, ID_REQ0, 127, 0);

        // Contention straight out of reset
        reset = 1'b1;
        applyStimulus(ID_REQ0, 1'b1, 10, 5);
        applyStimulus(ID_REQ1, 1'b1, 20, 6);
        tick();
        reset = 1'b0;
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b0, 0, 0);
        runBusy(10, 5, ID_REQ0, 15, 0);
        grantCheck(ID_REQ1);
        applyStimulus(ID_REQ1, 1'b0, 0, 0);
        runBusy(20, 6, ID_REQ1, 26, 0);

        // Pointer back at req0, then overflow on req1
        applyStimulus(ID_REQ0, 1'b1, 300, 100);
        applyStimulus(ID_REQ1, 1'b1, 511, 511);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b0, 0, 0);
        runBusy(300, 100, ID_REQ0, 400, 0);
        grantCheck(ID_REQ1);
        applyStimulus(ID_REQ1, 1'b0, 0, 0);
        runBusy(511, 511, ID_REQ1, OVF_SUM, 0);

        // Backpressure with req1 waiting
        applyStimulus(ID_REQ0, 1'b1, 7, 8);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b0, 0, 0);
        applyStimulus(ID_REQ1, 1'b1, 40, 2);
        runBusy(7, 8, ID_REQ0, 15, 5);
        grantCheck(ID_REQ1);
        applyStimulus(ID_REQ1, 1'b0, 0, 0);
        runBusy(40, 2, ID_REQ1, 42, 0);

        // Reset four cycles after the grant
        applyStimulus(ID_REQ1, 1'b1, 1, 1);
        grantCheck(ID_REQ1);
        applyStimulus(ID_REQ1, 1'b0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkOutput("abort_in0", 32'(add_in0), 0);
        checkOutput("abort_in1", 32'(add_in1), 0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("abort_rsp_id", 32'(rsp_id), 0);
        checkOutput("abort_rsp_sum", 32'(rsp_sum), 0);
        reset = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            checkOutput("abort_no_rsp", 32'(rsp_valid), 0);
            tick();
        end
        applyStimulus(ID_REQ1, 1'b1, 1, 1);
        grantCheck(ID_REQ1);
        applyStimulus(ID_REQ1, 1'b0, 0, 0);
        runBusy(1, 1, ID_REQ1, 2, 0);

        // Lone requester held valid for back-to-back adds
        applyStimulus(ID_REQ0, 1'b1, 1, 1);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b1, 2, 2);
        runBusy(1, 1, ID_REQ0, 2, 0);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b1, 3, 3);
        runBusy(2, 2, ID_REQ0, 4, 0);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b1, 511, 1);
        runBusy(3, 3, ID_REQ0, 6, 0);
        grantCheck(ID_REQ0);
        applyStimulus(ID_REQ0, 1'b0, 0, 0);
`ifdef ADDER_SHARE_SAT_EN
        runBusy(511, 1, ID_REQ0, 511, 0);
`else
        runBusy(511, 1, ID_REQ0, 512, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
